bht_ctrl: RTL and testbench

Branch history table controller for the fetch/execute branch prediction path. It owns an array of 2^IDX_W two-bit saturating counters using the snt/wnt/wt/st encoding. It also:
- sequences a table-initialisation sweep after reset or flush;
- serves one fetch lookup per cycle;
- applies one execute-stage outcome update per cycle, with same-cycle forwarding.

It sits between the fetch unit (lookup) and the branch-resolve stage (update), and replaces per-entry counter instances.

---
 rtl/bht_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_bht_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bht_ctrl.sv
//------------------------------------------------------------------------------
// bht_ctrl : branch history table of 2-bit saturating counters with init sweep,
//            one lookup + one update per cycle. Optional gshare via BHT_GSHARE_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bht_ctrl #(
  parameter int IDX_W = 7,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             lkp_valid,
  input  logic [PC_W-1:0]  lkp_pc,
  output logic             lkp_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_hist,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [IDX_W-1:0] upd_hist,
  output logic             upd_ready,
  output logic             busy
);

  localparam int         N        = 1 << IDX_W;
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [1:0] CNT_SNT  = 2'b00;
  localparam logic [1:0] CNT_WNT  = 2'b01;
  localparam logic [1:0] CNT_ST   = 2'b11;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0] pred_hist_q, pred_hist_d;
  logic [1:0]       tbl_q [N];

  logic             lkp_fire, upd_fire;
  logic [IDX_W-1:0] lkp_idx, upd_idx, hist_cur;
  logic [1:0]       upd_cur, upd_new, lkp_cnt;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_val;
  logic             unused_bits;

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  assign hist_cur    = ghr_q;
  assign lkp_idx     = lkp_pc[IDX_W+1:2] ^ ghr_q;
  assign upd_idx     = upd_pc[IDX_W+1:2] ^ upd_hist;
  assign unused_bits = ^{lkp_pc[PC_W-1:IDX_W+2], lkp_pc[1:0],
                         upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

  always_comb begin
    ghr_d = ghr_q;
    if (flush) begin
      ghr_d = '0;
    end else if (upd_fire) begin
      ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign hist_cur    = '0;
  assign lkp_idx     = lkp_pc[IDX_W+1:2];
  assign upd_idx     = upd_pc[IDX_W+1:2];
  assign unused_bits = ^{lkp_pc[PC_W-1:IDX_W+2], lkp_pc[1:0],
                         upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0], upd_hist};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_INIT: begin
        if (flush) begin
          sweep_d = '0;
        end else if (sweep_q == IDX_W'(N - 1)) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + IDX_W'(1);
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_INIT;
          sweep_d = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Output logic; flush withdraws acceptance in the same cycle
  always_comb begin
    busy      = 1'b1;
    lkp_ready = 1'b0;
    upd_ready = 1'b0;
    if (state_q == ST_RUN) begin
      busy      = 1'b0;
      lkp_ready = !flush;
      upd_ready = !flush;
    end
  end

  assign lkp_fire = lkp_valid && lkp_ready;
  assign upd_fire = upd_valid && upd_ready;

  always_comb begin
    upd_cur = tbl_q[upd_idx];
    upd_new = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CNT_ST) upd_new = upd_cur + 2'd1;
    end else begin
      if (upd_cur != CNT_SNT) upd_new = upd_cur - 2'd1;
    end
  end

  // Same-edge update to the looked-up entry is forwarded to the prediction
  always_comb begin
    lkp_cnt = tbl_q[lkp_idx];
    if (upd_fire && (upd_idx == lkp_idx)) lkp_cnt = upd_new;
    pred_valid_d = lkp_fire;
    pred_taken_d = lkp_fire && lkp_cnt[1];
    pred_hist_d  = lkp_fire ? hist_cur : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_hist_q  <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_hist_q  <= pred_hist_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_hist  = pred_hist_q;

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = upd_idx;
    wr_val = upd_new;
    if ((state_q == ST_INIT) && !flush) begin
      wr_en  = 1'b1;
      wr_idx = sweep_q;
      wr_val = CNT_WNT;
    end else if (upd_fire) begin
      wr_en = 1'b1;
    end
  end

  // Table contents are left unreset; the sweep defines them before use
  always_ff @(posedge clk) begin
    if (wr_en) tbl_q[wr_idx] <= wr_val;
  end

endmodule

`default_nettype wire

// File: tb/tb_bht_ctrl.sv
// Bench for bht_ctrl: behavioural table model checked every cycle plus
// directed vectors with literal expectations.
`default_nettype none

module tb_bht_ctrl;
  localparam int IDX_W = 7;
  localparam int PC_W  = 32;
  localparam int N     = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             lkp_valid = 1'b0;
  logic [PC_W-1:0]  lkp_pc = '0;
  logic             lkp_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_hist;
  logic             upd_valid = 1'b0;
  logic [PC_W-1:0]  upd_pc = '0;
  logic             upd_taken = 1'b0;
  logic [IDX_W-1:0] upd_hist = '0;
  logic             upd_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;

  bht_ctrl #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .lkp_valid(lkp_valid), .lkp_pc(lkp_pc), .lkp_ready(lkp_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_hist(pred_hist),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_hist(upd_hist), .upd_ready(upd_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: counters as integers, init as a countdown
  int m_tbl [N];
  int m_busy = 1, m_left = N, m_ghr = 0;
  int m_pv = 0, m_pt = 0, m_ph = 0;

  initial begin
    int lidx, uidx, hist;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1; m_left = N; m_ghr = 0; m_pv = 0; m_pt = 0; m_ph = 0;
      end else if (flush) begin
        m_busy = 1; m_left = N; m_ghr = 0; m_pv = 0;
      end else if (m_busy != 0) begin
        m_pv = 0;
        m_left--;
        if (m_left == 0) begin
          for (int i = 0; i < N; i++) m_tbl[i] = 1;
          m_busy = 0;
        end
      end else begin
        m_pv = 0;
        hist = m_ghr;
        lidx = ((lkp_pc >> 2) % N) ^ m_ghr;
        if (upd_valid) begin
`ifdef BHT_GSHARE_EN
          uidx = ((upd_pc >> 2) % N) ^ int'(upd_hist);
`else
          uidx = (upd_pc >> 2) % N;
`endif
          if (upd_taken) m_tbl[uidx] = (m_tbl[uidx] == 3) ? 3 : m_tbl[uidx] + 1;
          else           m_tbl[uidx] = (m_tbl[uidx] == 0) ? 0 : m_tbl[uidx] - 1;
`ifdef BHT_GSHARE_EN
          m_ghr = ((m_ghr << 1) | int'(upd_taken)) % N;
`endif
        end
        if (lkp_valid) begin
          m_pv = 1;
          m_pt = (m_tbl[lidx] >= 2) ? 1 : 0;
          m_ph = hist;
        end
      end
    end
  end

  // Compare process: every falling edge
  initial begin
    forever begin
      @(negedge clk);
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_lkp_ready", 32'(lkp_ready), 32'((m_busy == 0 && rst_n && !flush) ? 1 : 0));
      chk("m_upd_ready", 32'(upd_ready), 32'((m_busy == 0 && rst_n && !flush) ? 1 : 0));
      chk("m_pred_valid", 32'(pred_valid), 32'(m_pv));
      if (m_pv != 0 || !rst_n) begin
        chk("m_pred_taken", 32'(pred_taken), 32'(m_pt));
        chk("m_pred_hist", 32'(pred_hist), 32'(m_ph));
      end
    end
  end

  task automatic wait_init(input string nm);
    int n = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      n++;
      #1;
      if (!busy) break;
    end
    chk(nm, 32'(n), 32'd128);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [IDX_W-1:0] h);
    upd_pc = pc; upd_taken = tk; upd_hist = h; upd_valid = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic exp, input string nm);
    lkp_pc = pc; lkp_valid = 1'b1;
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_pv"}, 32'(pred_valid), 32'd1);
    chk(nm, 32'(pred_taken), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_lkp_ready", 32'(lkp_ready), 32'd0);
    chk("rst_upd_ready", 32'(upd_ready), 32'd0);
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_pred_hist", 32'(pred_hist), 32'd0);
    rst_n = 1'b1;
    wait_init("init_cycles");

    for (int i = 0; i < N; i++) lookup(32'(i) << 2, 1'b0, "all_wnt");

`ifdef BHT_GSHARE_EN
    upd(32'h40, 1'b1, '0);
    upd(32'h40, 1'b1, '0);
    lkp_pc = 32'h0; lkp_valid = 1'b1;
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    @(negedge clk);
    chk("gs_hist", 32'(pred_hist), 32'd3);
    chk("gs_idx3_wnt", 32'(pred_taken), 32'd0);
    @(posedge clk); #1;
    upd(32'h0, 1'b1, 7'd3);
    lookup(32'h10, 1'b1, "gs_entry3_wt");
    lookup(32'h1C, 1'b0, "gs_entry0_wnt");
    lookup(32'h0, 1'b0, "gs_entry7_wnt");
`else
    upd(32'h40, 1'b1, '0); lookup(32'h40, 1'b1, "seq_wt");
    upd(32'h40, 1'b1, '0); lookup(32'h40, 1'b1, "seq_st");
    upd(32'h40, 1'b1, '0); lookup(32'h40, 1'b1, "seq_st_sat");
    upd(32'h40, 1'b0, '0); lookup(32'h40, 1'b1, "seq_wt_dn");
    upd(32'h40, 1'b0, '0); lookup(32'h40, 1'b0, "seq_wnt");

    upd_pc = 32'h80; upd_taken = 1'b1; upd_valid = 1'b1;
    lkp_pc = 32'h80; lkp_valid = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0; lkp_valid = 1'b0;
    @(negedge clk);
    chk("fwd_pv", 32'(pred_valid), 32'd1);
    chk("fwd_taken", 32'(pred_taken), 32'd1);
    @(posedge clk); #1;

    repeat (3) upd(32'h40, 1'b1, '0);
    upd(32'h80, 1'b1, '0);
    lookup(32'h40, 1'b1, "pre_flush_sat");

    flush = 1'b1; lkp_pc = 32'h40; lkp_valid = 1'b1;
    upd_pc = 32'h40; upd_taken = 1'b0; upd_valid = 1'b1;
    #1;
    chk("flush_lkp_ready", 32'(lkp_ready), 32'd0);
    chk("flush_upd_ready", 32'(upd_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; lkp_valid = 1'b0; upd_valid = 1'b0;
    @(negedge clk);
    chk("flush_pv", 32'(pred_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    wait_init("flush_init_cycles");
    lookup(32'h40, 1'b0, "post_flush_40");
    lookup(32'h80, 1'b0, "post_flush_80");

    lkp_pc = 32'h40; lkp_valid = 1'b1;
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    chk("pre_rst_pv", 32'(pred_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_pv", 32'(pred_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    chk("arst_lkp_ready", 32'(lkp_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init("rst_run_init_cycles");

    upd(32'h40, 1'b1, '0);
    repeat (2) upd(32'h40, 1'b1, '0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("sweep50_busy", 32'(busy), 32'd1);
    chk("sweep50_upd_ready", 32'(upd_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init("sweep50_init_cycles");
    lookup(32'h40, 1'b0, "post_rst_40");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
